// File: rtl/speed_avg_filter_if.sv
// Sample/average bus between the encoder diff stage, the speed filter and its consumers.
// Latency: none, signal bundle only.
// Backpressure: none; the filter flags samples it cannot accept through overrun.
interface speed_avg_filter_if #(
  parameter int DATA_W = 32,
  parameter int LOG2_N = 3
);
  logic                       sample_valid;
  logic [DATA_W-1:0]          sample_in;
  logic                       clear;
  logic [DATA_W-1:0]          avg_out;
  logic                       avg_valid;
  logic [DATA_W+LOG2_N-1:0]   sum_out;
  logic [LOG2_N:0]            fill_count;
  logic                       overrun;

  // Producer side: the diff stage / test driver.
  modport master (
    output sample_valid, sample_in, clear,
    input  avg_out, avg_valid, sum_out, fill_count, overrun
  );

  // Filter side.
  modport slave (
    input  sample_valid, sample_in, clear,
    output avg_out, avg_valid, sum_out, fill_count, overrun
  );
endinterface

// File: rtl/speed_avg_filter.sv
// Moving-average speed filter: ring buffer of the last 2**LOG2_N deltas, running sum, avg = sum >>> LOG2_N.
// Latency: sample_valid at cycle t gives a one-cycle avg_valid at t+3; one sample accepted per 4 cycles.
// Backpressure: none; samples arriving while busy are dropped and set sticky overrun. SPEED_AVG_SAT_EN clamps input to +/-SAT_LIMIT.
module speed_avg_filter #(
  parameter int DATA_W    = 32,
  parameter int LOG2_N    = 3,
  parameter int SAT_LIMIT = 4096
) (
  input  logic             clk,
  input  logic             reset,
  speed_avg_filter_if.slave bus
);

  localparam int              N      = 1 << LOG2_N;
  localparam int              SW     = DATA_W + LOG2_N;
  localparam logic [LOG2_N:0] N_FILL = (LOG2_N + 1)'(N);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    UPDATE = 2'd2,
    EMIT   = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [DATA_W-1:0]    s_in;
  logic [DATA_W-1:0]    s_new;
  logic [DATA_W-1:0]    s_old;
  logic [SW-1:0]        sum_q;
  logic [SW-1:0]        sum_next;
  logic [LOG2_N-1:0]    wp_q;
  logic [LOG2_N:0]      fill_q;
  logic [DATA_W-1:0]    avg_q;
  logic                 avg_vld_q;
  logic                 ovr_q;
  logic                 full;
  logic                 take;
  logic                 commit;
  logic                 drop;
  logic [DATA_W-1:0]    ram [N];

  // Glitch rejection bound; only referenced when the clamp is compiled in.
  function automatic logic [DATA_W-1:0] sat_clamp(input logic [DATA_W-1:0] x);
    logic signed [DATA_W-1:0] hi, lo, v;
    hi = DATA_W'(SAT_LIMIT);
    lo = -hi;
    v  = x;
    if (v > hi)      sat_clamp = hi;
    else if (v < lo) sat_clamp = lo;
    else             sat_clamp = v;
  endfunction

`ifdef SPEED_AVG_SAT_EN
  assign s_in = sat_clamp(bus.sample_in);
`else
  assign s_in = bus.sample_in;
`endif

  assign full     = (fill_q == N_FILL);
  assign sum_next = sum_q + {{LOG2_N{s_new[DATA_W-1]}}, s_new}
                          - {{LOG2_N{s_old[DATA_W-1]}}, s_old};

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and per-state strobes; clear forces IDLE and suppresses all strobes.
  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    commit  = 1'b0;
    drop    = 1'b0;
    if (bus.clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.sample_valid) begin
            take    = 1'b1;
            state_d = READ;
          end
        end
        READ: begin
          drop    = bus.sample_valid;
          state_d = UPDATE;
        end
        UPDATE: begin
          drop    = bus.sample_valid;
          commit  = 1'b1;
          state_d = EMIT;
        end
        default: begin
          drop    = bus.sample_valid;
          state_d = IDLE;
        end
      endcase
    end
  end

  // Latch the incoming sample and fetch the slot it will evict (zero until the window is full).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_new <= '0;
      s_old <= '0;
    end else begin
      if (take) s_new <= s_in;
      if (state_q == READ) s_old <= full ? ram[wp_q] : '0;
    end
  end

  // Ring storage is deliberately not reset; unfilled slots are never read.
  always_ff @(posedge clk) begin
    if (commit) ram[wp_q] <= s_new;
  end

  // Running sum, pointers and output registers; avg is loaded with the new sum so it is valid during EMIT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum_q     <= '0;
      wp_q      <= '0;
      fill_q    <= '0;
      avg_q     <= '0;
      avg_vld_q <= 1'b0;
      ovr_q     <= 1'b0;
    end else if (bus.clear) begin
      sum_q     <= '0;
      wp_q      <= '0;
      fill_q    <= '0;
      avg_q     <= '0;
      avg_vld_q <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      avg_vld_q <= 1'b0;
      if (commit) begin
        sum_q     <= sum_next;
        wp_q      <= wp_q + 1'b1;
        if (!full) fill_q <= fill_q + 1'b1;
        avg_q     <= sum_next[SW-1:LOG2_N];
        avg_vld_q <= 1'b1;
      end
      if (drop) ovr_q <= 1'b1;
    end
  end

  assign bus.avg_out    = avg_q;
  assign bus.avg_valid  = avg_vld_q;
  assign bus.sum_out    = sum_q;
  assign bus.fill_count = fill_q;
  assign bus.overrun    = ovr_q;

endmodule

// File: tb/tb_speed_avg_filter.sv
// Self-checking bench for speed_avg_filter (N=8, DATA_W=32) against a queue-based window model.
// Latency: checks avg_valid exactly three cycles after each accepted strobe, one cycle wide.
// Backpressure: exercises dropped strobes (overrun), clear collisions and clear mid-update.
module tb_speed_avg_filter;

  localparam int DATA_W = 32;
  localparam int LOG2_N = 3;
  localparam int N      = 8;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;
  int   win[$];
  logic ovr_m;

  speed_avg_filter_if #(.DATA_W(DATA_W), .LOG2_N(LOG2_N)) bus ();

  speed_avg_filter #(.DATA_W(DATA_W), .LOG2_N(LOG2_N), .SAT_LIMIT(4096)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int mclamp(input int v);
`ifdef SPEED_AVG_SAT_EN
    if (v > 4096)  return 4096;
    if (v < -4096) return -4096;
`endif
    return v;
  endfunction

  function automatic longint msum();
    longint s = 0;
    foreach (win[i]) s += win[i];
    return s;
  endfunction

  // Floor division by N.
  function automatic longint mavg();
    longint s = msum();
    longint q = s / N;
    if (s < 0 && (s % N) != 0) q -= 1;
    return q;
  endfunction

  task automatic mpush(input int v);
    win.push_back(mclamp(v));
    if (win.size() > N) void'(win.pop_front());
  endtask

  task automatic mclear();
    win.delete();
    ovr_m = 1'b0;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic check_idle_outputs(input string tag);
    chk({tag, "_sum"},  $signed(bus.sum_out), msum());
    chk({tag, "_fill"}, bus.fill_count, win.size());
    chk({tag, "_ovr"},  bus.overrun, ovr_m);
    chk({tag, "_vld"},  bus.avg_valid, 0);
  endtask

  task automatic send(input int v);
    @(posedge clk); #1;
    bus.sample_valid = 1'b1;
    bus.sample_in    = v;
    @(posedge clk); #1;
    bus.sample_valid = 1'b0;
    mpush(v);
    @(negedge clk); chk("lat_t1", bus.avg_valid, 0);
    @(negedge clk); chk("lat_t2", bus.avg_valid, 0);
    @(negedge clk);
    chk("avg_vld", bus.avg_valid, 1);
    chk("avg_out", $signed(bus.avg_out), mavg());
    chk("sum_out", $signed(bus.sum_out), msum());
    chk("fill",    bus.fill_count, win.size());
    chk("ovr",     bus.overrun, ovr_m);
    @(negedge clk); chk("pulse_w", bus.avg_valid, 0);
  endtask

  task automatic do_clear();
    @(posedge clk); #1;
    bus.clear = 1'b1;
    @(posedge clk); #1;
    bus.clear = 1'b0;
    mclear();
    @(negedge clk);
    check_idle_outputs("clr");
    chk("clr_avg", bus.avg_out, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int v;
    n_cmp = 0;
    n_err = 0;
    ovr_m = 1'b0;
    reset = 1'b0;
    bus.sample_valid = 1'b0;
    bus.sample_in    = '0;
    bus.clear        = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    check_idle_outputs("rst");
    chk("rst_avg", bus.avg_out, 0);
    reset = 1'b1;

    // A few samples, then async reset in the middle of an update.
    send(100); send(-30); send(7);
    @(posedge clk); #1;
    bus.sample_valid = 1'b1;
    bus.sample_in    = 5;
    @(posedge clk); #1;
    bus.sample_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    mclear();
    check_idle_outputs("arst");
    chk("arst_avg", bus.avg_out, 0);
    @(negedge clk); reset = 1'b1;

    // Warm-up with +16: avg 2,4,...,16.
    for (int i = 0; i < N; i++) send(16);
    // Full window then -8: sum steps down to -64, wraps the ring.
    for (int i = 0; i < N; i++) send(-8);
    chk("wrap_avg", $signed(bus.avg_out), -8);

    // Single -1 rounds toward -inf.
    do_clear();
    send(-1);
    chk("neg_round", $signed(bus.avg_out), -1);

    // Strobe at t and t+2: second one dropped, overrun set.
    do_clear();
    @(posedge clk); #1;
    bus.sample_valid = 1'b1; bus.sample_in = 40;
    @(posedge clk); #1;
    bus.sample_valid = 1'b0;
    @(posedge clk); #1;
    bus.sample_valid = 1'b1; bus.sample_in = 999;
    @(posedge clk); #1;
    bus.sample_valid = 1'b0;
    mpush(40);
    ovr_m = 1'b1;
    @(negedge clk);
    chk("ovr_vld", bus.avg_valid, 1);
    chk("ovr_sum", $signed(bus.sum_out), msum());
    chk("ovr_flag", bus.overrun, 1);
    repeat (4) @(negedge clk);
    check_idle_outputs("ovr_idle");
    do_clear();

    // clear and sample_valid in the same cycle: sample dropped, no overrun.
    send(5);
    @(posedge clk); #1;
    bus.clear = 1'b1; bus.sample_valid = 1'b1; bus.sample_in = 77;
    @(posedge clk); #1;
    bus.clear = 1'b0; bus.sample_valid = 1'b0;
    mclear();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); chk("clrsv_vld", bus.avg_valid, 0);
    end
    check_idle_outputs("clrsv");

    // clear during UPDATE aborts the commit.
    send(10);
    @(posedge clk); #1;
    bus.sample_valid = 1'b1; bus.sample_in = 50;
    @(posedge clk); #1;
    bus.sample_valid = 1'b0;
    @(posedge clk); #1;
    bus.clear = 1'b1;
    @(posedge clk); #1;
    bus.clear = 1'b0;
    mclear();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk("clrupd_vld", bus.avg_valid, 0);
    end
    check_idle_outputs("clrupd");

    // Large sample: clamped only when saturation is compiled in.
    send(100000);
`ifdef SPEED_AVG_SAT_EN
    chk("sat_sum", $signed(bus.sum_out), 4096);
`else
    chk("sat_sum", $signed(bus.sum_out), 100000);
`endif

    // Full-scale positive and negative windows.
    do_clear();
    for (int i = 0; i < N; i++) send(32'h7FFF_FFFF);
    do_clear();
    for (int i = 0; i < N; i++) send(32'h8000_0000);

    // Randomized stream with occasional clears.
    do_clear();
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 11) == 0) begin
        do_clear();
      end else begin
        if ($urandom_range(0, 1) == 0) v = $urandom_range(0, 20000) - 10000;
        else                           v = $urandom;
        send(v);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
